// File: rtl/cacheline_beat_seq_pkg.sv
// Shared definitions for the cache line beat sequencer: FSM states and
// helpers that derive the beat count and beat index width from line geometry.
package cacheline_beat_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Number of beats needed to carry one line.
    function automatic int beats_per_line(input int line_w, input int beat_w);
        return line_w / beat_w;
    endfunction

    // Beat index width; kept at least 1 so a single-beat line still has a port.
    function automatic int idx_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/cacheline_beat_mux.sv
// Combinational word-select: slices one BEATLEN-wide beat out of the held line.
module cacheline_beat_mux
    import cacheline_beat_seq_pkg::*;
#(
    parameter int LINELEN = 512,
    parameter int BEATLEN = 64,
    parameter int IDXW    = idx_width(beats_per_line(LINELEN, BEATLEN))
) (
    input  logic [LINELEN-1:0] line,
    input  logic [IDXW-1:0]    sel,
    output logic [BEATLEN-1:0] beat
);

    localparam int BEATSPERLINE = beats_per_line(LINELEN, BEATLEN);

    // View the flat line as an array of beats; beat k sits at line[k*BEATLEN +: BEATLEN].
    logic [BEATSPERLINE-1:0][BEATLEN-1:0] beats;
    assign beats = line;

    generate
        if (BEATSPERLINE == 1) begin : g_single
            // Only one beat exists; the select carries no information.
            assign beat = beats[0];
        end else begin : g_multi
            // Index width exactly covers the beat range, so every sel is legal.
            assign beat = beats[sel];
        end
    endgenerate

endmodule

// File: rtl/cacheline_beat_seq.sv
// Streams a captured cache line out as BEATLEN-wide beats over valid/ready,
// starting at any beat and wrapping inside the line (critical word first).
module cacheline_beat_seq
    import cacheline_beat_seq_pkg::*;
#(
    parameter int LINELEN = 512,
    parameter int BEATLEN = 64,
    localparam int BEATSPERLINE = beats_per_line(LINELEN, BEATLEN),
    localparam int IDXW         = idx_width(BEATSPERLINE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Start,
    input  logic [IDXW-1:0]    StartBeat,
    input  logic [LINELEN-1:0] LineIn,
    input  logic               Abort,
    output logic               BeatValid,
    input  logic               BeatReady,
    output logic [BEATLEN-1:0] BeatData,
    output logic [IDXW-1:0]    BeatIdx,
    output logic               BeatLast,
    output logic               Busy,
    output logic               Done
);

    localparam logic [IDXW-1:0] LAST_CNT = IDXW'(BEATSPERLINE - 1);

    state_t             state, state_d;
    logic [LINELEN-1:0] line_q, line_d;
    logic [IDXW-1:0]    ptr, ptr_d;
    logic [IDXW-1:0]    count, count_d;
    logic [IDXW-1:0]    ptr_inc;
    logic [BEATLEN-1:0] mux_beat;

    // Pointer advance; power-of-2 beat count makes the natural wrap the
    // modulo wrap, and a single-beat line keeps the pointer pinned at 0.
    assign ptr_inc = (BEATSPERLINE == 1) ? '0 : ptr + IDXW'(1);

    // Next-state, datapath updates and registered-state outputs.
    always_comb begin
        state_d   = state;
        line_d    = line_q;
        ptr_d     = ptr;
        count_d   = count;
        BeatValid = 1'b0;
        BeatLast  = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        unique case (state)
            IDLE: begin
                // Abort outranks Start, so a simultaneous pair does not launch.
                if (Start && !Abort) begin
                    line_d  = LineIn;
                    ptr_d   = (BEATSPERLINE == 1) ? '0 : StartBeat;
                    count_d = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                BeatValid = 1'b1;
                Busy      = 1'b1;
                BeatLast  = (count == LAST_CNT);
                if (BeatReady) begin
                    ptr_d   = ptr_inc;
                    count_d = count + IDXW'(1);
                    if (count == LAST_CNT) state_d = DONE;
                end
                // A beat accepted alongside Abort still counts, but the line ends here.
                if (Abort) state_d = IDLE;
            end
            DONE: begin
                Busy    = 1'b1;
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and holding registers; reset clears everything including the line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            line_q <= '0;
            ptr    <= '0;
            count  <= '0;
        end else begin
            state  <= state_d;
            line_q <= line_d;
            ptr    <= ptr_d;
            count  <= count_d;
        end
    end

    // Index and data are only presented while streaming; zero otherwise.
    assign BeatIdx  = (state == STREAM) ? ptr : '0;
    assign BeatData = (state == STREAM) ? mux_beat : '0;

    cacheline_beat_mux #(
        .LINELEN (LINELEN),
        .BEATLEN (BEATLEN),
        .IDXW    (IDXW)
    ) u_mux (
        .line (line_q),
        .sel  (BeatIdx),
        .beat (mux_beat)
    );

endmodule

// File: tb/tb_cacheline_beat_seq.sv
// Directed bench for cacheline_beat_seq with the default 512/64 geometry.
module tb_cacheline_beat_seq;

    localparam int LINELEN = 512;
    localparam int BEATLEN = 64;
    localparam int NB      = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               Start;
    logic [2:0]         StartBeat;
    logic [LINELEN-1:0] LineIn;
    logic               Abort;
    logic               BeatValid;
    logic               BeatReady;
    logic [BEATLEN-1:0] BeatData;
    logic [2:0]         BeatIdx;
    logic               BeatLast;
    logic               Busy;
    logic               Done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    cacheline_beat_seq #(.LINELEN(LINELEN), .BEATLEN(BEATLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .StartBeat (StartBeat),
        .LineIn    (LineIn),
        .Abort     (Abort),
        .BeatValid (BeatValid),
        .BeatReady (BeatReady),
        .BeatData  (BeatData),
        .BeatIdx   (BeatIdx),
        .BeatLast  (BeatLast),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 clk = ~clk;

    // Expected beat k of a line built as beat k = mul*k + add.
    function automatic logic [63:0] bexp(input logic [63:0] mul, input logic [63:0] add, input int k);
        return mul * 64'(k) + add;
    endfunction

    function automatic logic [LINELEN-1:0] mkline(input logic [63:0] mul, input logic [63:0] add);
        logic [LINELEN-1:0] l;
        for (int k = 0; k < NB; k++) l[k*64 +: 64] = bexp(mul, add, k);
        return l;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_line(input logic [LINELEN-1:0] l, input logic [2:0] sb);
        Start = 1'b1;
        LineIn = l;
        StartBeat = sb;
        tick();
        Start = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [63:0] mul,
                            input logic [63:0] add, input bit last);
        chk({tag, " valid"}, 64'(BeatValid), 64'd1);
        chk({tag, " idx"},   64'(BeatIdx),   64'(idx));
        chk({tag, " data"},  BeatData,       bexp(mul, add, idx));
        chk({tag, " last"},  64'(BeatLast),  64'(last));
        chk({tag, " busy"},  64'(Busy),      64'd1);
        chk({tag, " done"},  64'(Done),      64'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valid"}, 64'(BeatValid), 64'd0);
        chk({tag, " busy"},  64'(Busy),      64'd0);
        chk({tag, " done"},  64'(Done),      64'd0);
        chk({tag, " last"},  64'(BeatLast),  64'd0);
        chk({tag, " idx"},   64'(BeatIdx),   64'd0);
        chk({tag, " data"},  BeatData,       64'd0);
    endtask

    localparam logic [63:0] M1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] A1 = 64'h0;
    localparam logic [63:0] M2 = 64'h0101_0000_0000_0003;
    localparam logic [63:0] A2 = 64'hA5A5_0000_0000_0000;
    localparam logic [63:0] M3 = 64'h0000_0F00_0000_0011;
    localparam logic [63:0] A3 = 64'h5A00_0000_C0DE_0000;

    initial begin
        int s;
        reset = 1'b0; Start = 1'b0; StartBeat = '0; LineIn = '0; Abort = 1'b0; BeatReady = 1'b1;

        // Reset held for 3 cycles, then released.
        repeat (3) tick();
        chk_idle("reset");
        reset = 1'b1;
        tick();
        chk_idle("post_reset");

        // Aligned full line, consumer always ready.
        start_line(mkline(M1, A1), 3'd0);
        s = cyc;
        for (int i = 0; i < NB; i++) begin
            chk_beat($sformatf("aligned b%0d", i), i, M1, A1, i == NB-1);
            tick();
        end
        chk("aligned done_cycle", 64'(cyc - s), 64'd8);
        chk("aligned done", 64'(Done), 64'd1);
        chk("aligned done_busy", 64'(Busy), 64'd1);
        chk("aligned done_valid", 64'(BeatValid), 64'd0);
        tick();
        chk_idle("aligned end");

        // Critical word first, wraps 5,6,7,0..4.
        start_line(mkline(M1, A1), 3'd5);
        for (int i = 0; i < NB; i++) begin
            chk_beat($sformatf("wrap b%0d", i), (5 + i) % NB, M1, A1, i == NB-1);
            tick();
        end
        chk("wrap done", 64'(Done), 64'd1);
        tick();
        chk_idle("wrap end");

        // Backpressure: four stalled cycles on beat 2.
        start_line(mkline(M2, A2), 3'd0);
        s = cyc;
        chk_beat("bp b0", 0, M2, A2, 1'b0);
        tick();
        chk_beat("bp b1", 1, M2, A2, 1'b0);
        tick();
        chk_beat("bp b2", 2, M2, A2, 1'b0);
        BeatReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_beat($sformatf("bp stall%0d", i), 2, M2, A2, 1'b0);
        end
        BeatReady = 1'b1;
        for (int i = 0; i < 30 && !Done; i++) tick();
        chk("bp done", 64'(Done), 64'd1);
        chk("bp done_cycle", 64'(cyc - s), 64'd12);
        tick();
        chk_idle("bp end");

        // Abort on beat 3 with a simultaneous handshake; no Done pulse.
        start_line(mkline(M1, A1), 3'd0);
        repeat (3) tick();
        chk_beat("abort b3", 3, M1, A1, 1'b0);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk_idle("abort next");
        tick();
        chk("abort no_done", 64'(Done), 64'd0);

        // Fresh line after the abort, starting at beat 6.
        start_line(mkline(M3, A3), 3'd6);
        s = cyc;
        chk_beat("fresh b6", 6, M3, A3, 1'b0);
        tick();
        chk_beat("fresh b7", 7, M3, A3, 1'b0);
        tick();
        chk_beat("fresh b0", 0, M3, A3, 1'b0);
        repeat (5) tick();
        chk_beat("fresh b5", 5, M3, A3, 1'b1);
        tick();
        chk("fresh done_cycle", 64'(cyc - s), 64'd8);
        chk("fresh done", 64'(Done), 64'd1);
        tick();

        // Start while busy is ignored; reset mid-transfer wins.
        start_line(mkline(M1, A1), 3'd0);
        repeat (4) tick();
        chk_beat("busy b4", 4, M1, A1, 1'b0);
        start_line(mkline(M3, A3), 3'd1);
        chk_beat("busy b5", 5, M1, A1, 1'b0);
        tick();
        chk_beat("busy b6", 6, M1, A1, 1'b0);
        reset = 1'b0;
        tick();
        chk_idle("midreset");
        reset = 1'b1;
        tick();
        chk_idle("midreset after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
